// File: rtl/wg_dispatch_ctrl_pkg.sv
// Shared widths, FSM state encoding and descriptor struct for the work-group dispatcher.
package wg_dispatch_ctrl_pkg;

  localparam int WG_ID_W     = 8;
  localparam int WF_COUNT_W  = 4;
  localparam int WAVE_ITEM_W = 6;
  localparam int MEM_ADDR_W  = 32;
  localparam int VGPR_ID_W   = 8;
  localparam int SGPR_ID_W   = 8;
  localparam int LDS_ID_W    = 10;
  localparam int GDS_ID_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [WG_ID_W-1:0]     num_wg;
    logic [WF_COUNT_W-1:0]  num_wf;
    logic [WAVE_ITEM_W-1:0] wf_size;
    logic [MEM_ADDR_W-1:0]  start_pc;
    logic [MEM_ADDR_W-1:0]  pds_stride;
    logic [MEM_ADDR_W-1:0]  csr_knl;
    logic [VGPR_ID_W:0]     vgpr_pw;
    logic [SGPR_ID_W:0]     sgpr_pw;
    logic [LDS_ID_W:0]      lds;
  } knl_desc_t;

endpackage

// File: rtl/wg_inflight_cnt.sv
// Outstanding work-group counter: up on issue, down on completion, sticky underflow flag.
module wg_inflight_cnt #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full,
  output logic             o_err
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_zero;
  logic             w_dec_ok;

  assign w_zero   = (r_cnt == '0);
  // A completion with nothing outstanding is flagged, never counted.
  assign w_dec_ok = i_dec && !w_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_dec && w_zero) r_err <= 1'b1;
      if (i_clr)                    r_cnt <= '0;
      else if (i_inc && !w_dec_ok)  r_cnt <= r_cnt + 1'b1;
      else if (!i_inc && w_dec_ok)  r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_full = (r_cnt >= CNT_W'(MAX_INFLIGHT));
  assign o_err  = r_err;

endmodule

// File: rtl/wg_dispatch_ctrl.sv
// Kernel descriptor -> per-WG host_req issuer with bounded in-flight WGs.
// Optional WG_DISPATCH_PERF_EN adds perf_cycles_o (cycles spent in ISSUE+DRAIN).
module wg_dispatch_ctrl
  import wg_dispatch_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
`ifdef WG_DISPATCH_PERF_EN
  , parameter int PERF_W     = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   knl_valid_i,
  output logic                   knl_ready_o,
  input  logic [WG_ID_W-1:0]     knl_num_wg_i,
  input  logic [WF_COUNT_W-1:0]  knl_num_wf_i,
  input  logic [WAVE_ITEM_W-1:0] knl_wf_size_i,
  input  logic [MEM_ADDR_W-1:0]  knl_start_pc_i,
  input  logic [MEM_ADDR_W-1:0]  knl_pds_base_i,
  input  logic [MEM_ADDR_W-1:0]  knl_pds_stride_i,
  input  logic [MEM_ADDR_W-1:0]  knl_csr_knl_i,
  input  logic [VGPR_ID_W:0]     knl_vgpr_per_wf_i,
  input  logic [SGPR_ID_W:0]     knl_sgpr_per_wf_i,
  input  logic [LDS_ID_W:0]      knl_lds_size_i,
  output logic                   host_req_valid_o,
  input  logic                   host_req_ready_i,
  output logic [WG_ID_W-1:0]     host_req_wg_id_o,
  output logic [WF_COUNT_W-1:0]  host_req_num_wf_o,
  output logic [WAVE_ITEM_W-1:0] host_req_wf_size_o,
  output logic [MEM_ADDR_W-1:0]  host_req_start_pc_o,
  output logic [MEM_ADDR_W-1:0]  host_req_pds_baseaddr_o,
  output logic [MEM_ADDR_W-1:0]  host_req_csr_knl_o,
  output logic [VGPR_ID_W:0]     host_req_vgpr_size_total_o,
  output logic [SGPR_ID_W:0]     host_req_sgpr_size_total_o,
  output logic [LDS_ID_W:0]      host_req_lds_size_total_o,
  output logic [GDS_ID_W:0]      host_req_gds_size_total_o,
  output logic [MEM_ADDR_W-1:0]  host_req_gds_baseaddr_o,
  output logic [VGPR_ID_W:0]     host_req_vgpr_size_per_wf_o,
  output logic [SGPR_ID_W:0]     host_req_sgpr_size_per_wf_o,
  input  logic                   host_rsp_valid_i,
  output logic                   host_rsp_ready_o,
  input  logic [WG_ID_W-1:0]     host_rsp_wg_id_i,
  output logic                   busy_o,
  output logic                   knl_done_o,
  output logic [CNT_W-1:0]       inflight_o,
  output logic                   err_o
`ifdef WG_DISPATCH_PERF_EN
  , output logic [PERF_W-1:0]    perf_cycles_o
`endif
);

  state_e                r_state, w_state_nxt;
  knl_desc_t             r_desc;
  logic [WG_ID_W-1:0]    r_next_wg;
  logic [MEM_ADDR_W-1:0] r_pds_addr;
  logic [VGPR_ID_W:0]    r_vgpr_tot;
  logic [SGPR_ID_W:0]    r_sgpr_tot;
  logic                  w_knl_hs, w_req_hs, w_rsp_hs, w_last_wg, w_full, w_err;
  logic [CNT_W-1:0]      w_inflight;
  logic                  w_unused_rsp_id;

  // Completions are counted only; the returned id carries no routing meaning here.
  assign w_unused_rsp_id = ^host_rsp_wg_id_i;

  // Handshake-facing outputs are gated by rst_n so they drop in the cycle reset is seen.
  assign knl_ready_o      = rst_n && (r_state == ST_IDLE);
  assign host_req_valid_o = rst_n && (r_state == ST_ISSUE) && !w_full;
  assign host_rsp_ready_o = rst_n;

  assign w_knl_hs  = knl_valid_i && knl_ready_o;
  assign w_req_hs  = host_req_valid_o && host_req_ready_i;
  assign w_rsp_hs  = host_rsp_valid_i && host_rsp_ready_o;
  assign w_last_wg = (r_next_wg == r_desc.num_wg - 1'b1);

  wg_inflight_cnt #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_knl_hs),
    .i_inc (w_req_hs),
    .i_dec (w_rsp_hs),
    .o_cnt (w_inflight),
    .o_full(w_full),
    .o_err (w_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_knl_hs) w_state_nxt = (knl_num_wg_i == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (w_req_hs && w_last_wg) w_state_nxt = ST_DRAIN;
      // No issue happens in DRAIN, so the last completion is the one seen at count 1.
      ST_DRAIN: if (w_rsp_hs && (w_inflight == CNT_W'(1))) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_desc     <= '0;
      r_next_wg  <= '0;
      r_pds_addr <= '0;
      r_vgpr_tot <= '0;
      r_sgpr_tot <= '0;
    end else if (w_knl_hs) begin
      r_desc.num_wg     <= knl_num_wg_i;
      r_desc.num_wf     <= knl_num_wf_i;
      r_desc.wf_size    <= knl_wf_size_i;
      r_desc.start_pc   <= knl_start_pc_i;
      r_desc.pds_stride <= knl_pds_stride_i;
      r_desc.csr_knl    <= knl_csr_knl_i;
      r_desc.vgpr_pw    <= knl_vgpr_per_wf_i;
      r_desc.sgpr_pw    <= knl_sgpr_per_wf_i;
      r_desc.lds        <= knl_lds_size_i;
      r_next_wg         <= '0;
      r_pds_addr        <= knl_pds_base_i;
      // Totals wrap to the port width by construction of the multiply width.
      r_vgpr_tot        <= (VGPR_ID_W+1)'(knl_num_wf_i) * knl_vgpr_per_wf_i;
      r_sgpr_tot        <= (SGPR_ID_W+1)'(knl_num_wf_i) * knl_sgpr_per_wf_i;
    end else if (w_req_hs) begin
      r_next_wg  <= r_next_wg + 1'b1;
      r_pds_addr <= r_pds_addr + r_desc.pds_stride;
    end
  end

`ifdef WG_DISPATCH_PERF_EN
  logic [PERF_W-1:0] r_perf;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_perf <= '0;
    else if (w_knl_hs)
      r_perf <= '0;
    else if (((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) && !(&r_perf))
      r_perf <= r_perf + 1'b1;
  end

  assign perf_cycles_o = r_perf;
`endif

  assign host_req_wg_id_o            = r_next_wg;
  assign host_req_num_wf_o           = r_desc.num_wf;
  assign host_req_wf_size_o          = r_desc.wf_size;
  assign host_req_start_pc_o         = r_desc.start_pc;
  assign host_req_pds_baseaddr_o     = r_pds_addr;
  assign host_req_csr_knl_o          = r_desc.csr_knl;
  assign host_req_vgpr_size_total_o  = r_vgpr_tot;
  assign host_req_sgpr_size_total_o  = r_sgpr_tot;
  assign host_req_lds_size_total_o   = r_desc.lds;
  assign host_req_gds_size_total_o   = '0;
  assign host_req_gds_baseaddr_o     = '0;
  assign host_req_vgpr_size_per_wf_o = r_desc.vgpr_pw;
  assign host_req_sgpr_size_per_wf_o = r_desc.sgpr_pw;

  assign busy_o     = (r_state != ST_IDLE);
  assign knl_done_o = (r_state == ST_DONE);
  assign inflight_o = w_inflight;
  assign err_o      = w_err;

endmodule

// File: tb/tb_wg_dispatch_ctrl.sv
// Directed bench for wg_dispatch_ctrl: zero-WG kernel, back-to-back issue, in-flight cap,
// stall stability, simultaneous issue/retire, error flag, mid-issue reset, totals.
module tb_wg_dispatch_ctrl;
  import wg_dispatch_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   knl_valid_i, knl_ready_o;
  logic [WG_ID_W-1:0]     knl_num_wg_i;
  logic [WF_COUNT_W-1:0]  knl_num_wf_i;
  logic [WAVE_ITEM_W-1:0] knl_wf_size_i;
  logic [MEM_ADDR_W-1:0]  knl_start_pc_i, knl_pds_base_i, knl_pds_stride_i, knl_csr_knl_i;
  logic [VGPR_ID_W:0]     knl_vgpr_per_wf_i;
  logic [SGPR_ID_W:0]     knl_sgpr_per_wf_i;
  logic [LDS_ID_W:0]      knl_lds_size_i;
  logic                   host_req_valid_o, host_req_ready_i;
  logic [WG_ID_W-1:0]     host_req_wg_id_o;
  logic [WF_COUNT_W-1:0]  host_req_num_wf_o;
  logic [WAVE_ITEM_W-1:0] host_req_wf_size_o;
  logic [MEM_ADDR_W-1:0]  host_req_start_pc_o, host_req_pds_baseaddr_o, host_req_csr_knl_o;
  logic [VGPR_ID_W:0]     host_req_vgpr_size_total_o, host_req_vgpr_size_per_wf_o;
  logic [SGPR_ID_W:0]     host_req_sgpr_size_total_o, host_req_sgpr_size_per_wf_o;
  logic [LDS_ID_W:0]      host_req_lds_size_total_o;
  logic [GDS_ID_W:0]      host_req_gds_size_total_o;
  logic [MEM_ADDR_W-1:0]  host_req_gds_baseaddr_o;
  logic                   host_rsp_valid_i, host_rsp_ready_o;
  logic [WG_ID_W-1:0]     host_rsp_wg_id_i;
  logic                   busy_o, knl_done_o, err_o;
  logic [2:0]             inflight_o;
`ifdef WG_DISPATCH_PERF_EN
  logic [31:0]            perf_cycles_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wg_dispatch_ctrl dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .knl_valid_i                (knl_valid_i),
    .knl_ready_o                (knl_ready_o),
    .knl_num_wg_i               (knl_num_wg_i),
    .knl_num_wf_i               (knl_num_wf_i),
    .knl_wf_size_i              (knl_wf_size_i),
    .knl_start_pc_i             (knl_start_pc_i),
    .knl_pds_base_i             (knl_pds_base_i),
    .knl_pds_stride_i           (knl_pds_stride_i),
    .knl_csr_knl_i              (knl_csr_knl_i),
    .knl_vgpr_per_wf_i          (knl_vgpr_per_wf_i),
    .knl_sgpr_per_wf_i          (knl_sgpr_per_wf_i),
    .knl_lds_size_i             (knl_lds_size_i),
    .host_req_valid_o           (host_req_valid_o),
    .host_req_ready_i           (host_req_ready_i),
    .host_req_wg_id_o           (host_req_wg_id_o),
    .host_req_num_wf_o          (host_req_num_wf_o),
    .host_req_wf_size_o         (host_req_wf_size_o),
    .host_req_start_pc_o        (host_req_start_pc_o),
    .host_req_pds_baseaddr_o    (host_req_pds_baseaddr_o),
    .host_req_csr_knl_o         (host_req_csr_knl_o),
    .host_req_vgpr_size_total_o (host_req_vgpr_size_total_o),
    .host_req_sgpr_size_total_o (host_req_sgpr_size_total_o),
    .host_req_lds_size_total_o  (host_req_lds_size_total_o),
    .host_req_gds_size_total_o  (host_req_gds_size_total_o),
    .host_req_gds_baseaddr_o    (host_req_gds_baseaddr_o),
    .host_req_vgpr_size_per_wf_o(host_req_vgpr_size_per_wf_o),
    .host_req_sgpr_size_per_wf_o(host_req_sgpr_size_per_wf_o),
    .host_rsp_valid_i           (host_rsp_valid_i),
    .host_rsp_ready_o           (host_rsp_ready_o),
    .host_rsp_wg_id_i           (host_rsp_wg_id_i),
    .busy_o                     (busy_o),
    .knl_done_o                 (knl_done_o),
    .inflight_o                 (inflight_o),
    .err_o                      (err_o)
`ifdef WG_DISPATCH_PERF_EN
    , .perf_cycles_o            (perf_cycles_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [WG_ID_W-1:0] nwg, input logic [WF_COUNT_W-1:0] nwf,
                        input logic [31:0] base, input logic [31:0] stride,
                        input logic [VGPR_ID_W:0] vpw, input logic [SGPR_ID_W:0] spw);
    knl_num_wg_i      = nwg;
    knl_num_wf_i      = nwf;
    knl_pds_base_i    = base;
    knl_pds_stride_i  = stride;
    knl_vgpr_per_wf_i = vpw;
    knl_sgpr_per_wf_i = spw;
    knl_valid_i       = 1'b1;
    tick();
    knl_valid_i       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; knl_valid_i = 1'b0; host_req_ready_i = 1'b0;
    host_rsp_valid_i = 1'b0; host_rsp_wg_id_i = '0;
    knl_num_wg_i = '0; knl_num_wf_i = '0; knl_pds_base_i = '0; knl_pds_stride_i = '0;
    knl_vgpr_per_wf_i = '0; knl_sgpr_per_wf_i = '0;
    knl_wf_size_i = 6'd32; knl_start_pc_i = 32'h0000_0400;
    knl_csr_knl_i = 32'h0000_0800; knl_lds_size_i = 11'h40;

    // Reset state
    tick();
    chk("rst_knl_ready", knl_ready_o, 0);
    chk("rst_req_valid", host_req_valid_o, 0);
    chk("rst_rsp_ready", host_rsp_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_done", knl_done_o, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_knl_ready", knl_ready_o, 1);
    chk("idle_rsp_ready", host_rsp_ready_o, 1);

    // 1: zero-WG kernel goes straight to DONE
    launch(8'd0, 4'd1, 32'h0, 32'h0, 9'd1, 9'd1);
    chk("t1_done", knl_done_o, 1);
    chk("t1_valid", host_req_valid_o, 0);
    chk("t1_busy", busy_o, 1);
    tick();
    chk("t1_done_clr", knl_done_o, 0);
    chk("t1_busy_clr", busy_o, 0);
    chk("t1_ready", knl_ready_o, 1);

    // 2: three WGs back-to-back, then three completions
    host_req_ready_i = 1'b1;
    launch(8'd3, 4'd4, 32'h9000_0000, 32'h100, 9'd32, 9'd16);
    chk("t2_valid0", host_req_valid_o, 1);
    chk("t2_id0", host_req_wg_id_o, 0);
    chk("t2_pds0", host_req_pds_baseaddr_o, 64'h9000_0000);
    chk("t2_vgpr_tot", host_req_vgpr_size_total_o, 128);
    chk("t2_sgpr_tot", host_req_sgpr_size_total_o, 64);
    chk("t2_pc", host_req_start_pc_o, 64'h400);
    chk("t2_gds", host_req_gds_size_total_o, 0);
    tick();
    chk("t2_id1", host_req_wg_id_o, 1);
    chk("t2_pds1", host_req_pds_baseaddr_o, 64'h9000_0100);
    chk("t2_valid1", host_req_valid_o, 1);
    tick();
    chk("t2_id2", host_req_wg_id_o, 2);
    chk("t2_pds2", host_req_pds_baseaddr_o, 64'h9000_0200);
    chk("t2_inflight2", inflight_o, 2);
    tick();
    chk("t2_drain_valid", host_req_valid_o, 0);
    chk("t2_inflight3", inflight_o, 3);
    host_rsp_valid_i = 1'b1;
    tick();
    chk("t2_rsp1", inflight_o, 2);
    tick();
    chk("t2_rsp2", inflight_o, 1);
    chk("t2_no_done", knl_done_o, 0);
    tick();
    host_rsp_valid_i = 1'b0;
    chk("t2_done", knl_done_o, 1);
    chk("t2_inflight0", inflight_o, 0);
`ifdef WG_DISPATCH_PERF_EN
    chk("t6_perf", perf_cycles_o, 6);
`endif
    tick();
    chk("t2_idle", busy_o, 0);
    chk("t2_err", err_o, 0);
`ifdef WG_DISPATCH_PERF_EN
    chk("t6_perf_hold", perf_cycles_o, 6);
`endif

    // 3/4: cap at 4 in flight, stall stability, pds wrap, issue+retire together
    launch(8'd6, 4'd2, 32'hFFFF_FF00, 32'h40, 9'd8, 9'd8);
    tick(); tick(); tick(); tick();
    chk("t3_inflight4", inflight_o, 4);
    chk("t3_capped", host_req_valid_o, 0);
    tick();
    chk("t3_still_capped", host_req_valid_o, 0);
    chk("t3_hold_inflight", inflight_o, 4);
    host_rsp_valid_i = 1'b1;
    tick();
    host_rsp_valid_i = 1'b0;
    chk("t3_reopen", host_req_valid_o, 1);
    chk("t3_id4", host_req_wg_id_o, 4);
    chk("t3_pds_wrap", host_req_pds_baseaddr_o, 0);
    chk("t3_inflight3", inflight_o, 3);
    host_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_valid", host_req_valid_o, 1);
      chk("t4_stall_id", host_req_wg_id_o, 4);
      chk("t4_stall_pds", host_req_pds_baseaddr_o, 0);
    end
    host_req_ready_i = 1'b1;
    host_rsp_valid_i = 1'b1;
    tick();
    host_rsp_valid_i = 1'b0;
    chk("t4_same_cycle", inflight_o, 3);
    chk("t4_id5", host_req_wg_id_o, 5);
    chk("t4_pds5", host_req_pds_baseaddr_o, 64'h40);
    tick();
    chk("t4_drain", host_req_valid_o, 0);
    chk("t4_inflight4", inflight_o, 4);
    host_rsp_valid_i = 1'b1;
    tick(); tick(); tick();
    chk("t4_inflight1", inflight_o, 1);
    tick();
    host_rsp_valid_i = 1'b0;
    chk("t4_done", knl_done_o, 1);
    tick();
    chk("t4_idle", busy_o, 0);

    // 5: completion in IDLE raises sticky err; reset mid-ISSUE clears everything
    host_rsp_valid_i = 1'b1;
    tick();
    host_rsp_valid_i = 1'b0;
    chk("t5_err", err_o, 1);
    chk("t5_inflight0", inflight_o, 0);
    tick();
    chk("t5_err_sticky", err_o, 1);
    host_req_ready_i = 1'b0;
    launch(8'd2, 4'd15, 32'h10, 32'h10, 9'd8, 9'h1FF);
    chk("t5_valid", host_req_valid_o, 1);
    chk("t6_vgpr_tot", host_req_vgpr_size_total_o, 120);
    chk("t6_sgpr_trunc", host_req_sgpr_size_total_o, 64'h1F1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid_now", host_req_valid_o, 0);
    tick();
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_err", err_o, 0);
    chk("t5_rst_pds", host_req_pds_baseaddr_o, 0);
    chk("t5_rst_vgpr", host_req_vgpr_size_total_o, 0);
    chk("t5_rst_ready", knl_ready_o, 0);
    chk("t5_rst_rsp_ready", host_rsp_ready_o, 0);
    rst_n = 1'b1;
    tick();
    chk("t5_post_ready", knl_ready_o, 1);
    chk("t5_post_inflight", inflight_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
